store_aux_rmw: RTL and testbench
================================

// Module: store_aux_rmw
// PURPOSE
//  Store-side counterpart of the load size/extract path: performs sw/sh/sb into word-wide memory.
//  Word stores write directly. Half/byte stores do a read-modify-write: read the word, merge the low lane(s), write it back.
//  Sits between the control FSM (start/size/done handshake) and the memory port, on the B-register -> memory path.
// PARAMETERS
//  MEM_RD_LATENCY  1   cycles from mem_addr valid to mem_rdata valid; legal range >= 1
//  ADDR_W          32  address width
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  start        in   1       request pulse; sampled only in IDLE
//  SScontroler  in   2       00 word, 01 half, 10 byte, 11 no-op
//  addr         in   ADDR_W  word address of the store
//  B_in         in   32      store data (register rt)
//  busy         out  1       high in every state except IDLE
//  done         out  1       one-cycle completion pulse
//  align_err    out  1       misaligned half/byte lane; meaningful only with STORE_LANE_EN
//  mem_addr     out  ADDR_W  memory address
//  mem_wr       out  1       memory write strobe, one cycle per store
//  mem_wdata    out  32      memory write data
//  mem_rdata    in   32      memory read data
// BEHAVIOUR
//  Reset values: busy=0, done=0, align_err=0, mem_wr=0, mem_addr=0, mem_wdata=0; FSM in IDLE.
//  Input latch: on a start edge in IDLE, latch addr, B_in and SScontroler. start outside IDLE is ignored.
//  States: IDLE, READ, MERGE, WRITE, DONE.
//   IDLE  -> WRITE  start & 00; mem_wdata <= B_in.
//   IDLE  -> READ   start & 01/10.
//   IDLE  -> DONE   start & 11; no memory access.
//   READ  -> MERGE  after MEM_RD_LATENCY cycles; mem_addr = latched addr, mem_wr=0. A counter counts the cycles.
//   MERGE -> WRITE  capture merged word into the write register:
//                   half = {mem_rdata[31:16], B[15:0]}; byte = {mem_rdata[31:8], B[7:0]}.
//   WRITE -> DONE   mem_wr=1 for exactly this cycle; mem_addr and mem_wdata stable.
//   DONE  -> IDLE   done=1 for exactly this cycle.
//  Latency, counted from the start edge (cycle 0):
//   word   mem_wr in cycle 1, done in cycle 2.
//   half/byte  mem_wr in cycle L+2, done in cycle L+3, where L = MEM_RD_LATENCY.
//   no-op  done in cycle 1.
//  mem_addr holds the latched addr from READ through DONE; it returns to 0 in IDLE.
//  Width rules: the unmerged upper bits always come from the memory word.
//   B_in bits above the lane width are discarded; no sign or zero extension.
//  Reset mid-operation: the FSM returns to IDLE and mem_wr drops immediately (asynchronously); no partial write.
//  start asserted in the same cycle as DONE is ignored; a new start is accepted in the next IDLE cycle.
// CONFIGURATION
//  STORE_LANE_EN defined: the lane is selected by addr[1:0], and mem_addr = {addr[ADDR_W-1:2], 2'b00}.
//   half:  addr[1]=0 -> bits [15:0], addr[1]=1 -> bits [31:16].
//   byte:  lane addr[1:0] -> bits [8*k+7 : 8*k].
//   Half with addr[0]=1: align_err=1 in the DONE cycle, no READ/WRITE is performed, and done still pulses.
//  STORE_LANE_EN undefined: the lane is always the low half/byte; addr is passed through unmodified; align_err is tied to 0.
// STRUCTURE
//  Package store_pkg: size codes SZ_WORD/SZ_HALF/SZ_BYTE/SZ_NOP (2'b00..2'b11) and state encodings (IDLE..DONE).
//  Sub-module store_merge (combinational): inputs old word, B, size, lane; output merged word.
//   It is shared with a future load/store unit.
//  Top level holds the FSM, the latency counter and the latched registers.
// TESTING
//  1. sw: addr=0x40, B=0xDEADBEEF, SS=00 -> mem_wr in cycle 1 with wdata 0xDEADBEEF; done in cycle 2; no read cycles.
//  2. sh, L=1: mem[0x40]=0x11223344, B=0xAAAA5555, SS=01 -> write 0x11225555 in cycle 3; done in cycle 4.
//  3. sb, L=3: mem[0x40]=0x11223344, B=0x000000CC, SS=10 -> write 0x112233CC in cycle 5; done in cycle 6.
//  4. start pulsed during READ/WRITE -> ignored; exactly one mem_wr; busy stays high until done.
//  5. reset low during READ of an sh -> busy=0 and mem_wr=0 immediately; no write after reset is released.
//  6. STORE_LANE_EN, sb addr=0x43, B=0x7F, mem=0x11223344 -> write 0x7F223344 to 0x40.
//     sh addr=0x41 -> align_err=1 with done, no mem_wr.

Source files
------------

// File: rtl/store_aux_rmw_pkg.sv
// store_pkg: shared encodings for the store path.
//   size_e  : store size codes as driven by SScontroler (word/half/byte/no-op)
//   state_e : store_aux_rmw FSM states
package store_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_NOP  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/store_aux_rmw_if.sv
// store_aux_rmw_if: word-wide memory port of the store path.
//   mem_addr  : word address (master -> memory)
//   mem_wr    : one-cycle write strobe (master -> memory)
//   mem_wdata : write data (master -> memory)
//   mem_rdata : read data, valid MEM_RD_LATENCY cycles after mem_addr (memory -> master)
interface store_aux_rmw_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (output mem_addr, mem_wr, mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, mem_wr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/store_aux_rmw_merge.sv
// store_merge: combinational lane merge for sub-word stores.
//   old_word : word currently in memory
//   b        : store data; only the low half/byte is used for sub-word sizes
//   size     : store size code
//   lane     : byte lane (half uses lane[1] only)
//   merged   : old_word with the selected lane replaced by b's low bits
module store_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] b,
  input  size_e       size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_WORD: merged = b;
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = b[15:0];
        else         merged[15:0]  = b[15:0];
      end
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = b[7:0];
          2'd1:    merged[15:8]  = b[7:0];
          2'd2:    merged[23:16] = b[7:0];
          default: merged[31:24] = b[7:0];
        endcase
      end
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_aux_rmw.sv
// store_aux_rmw: sw/sh/sb into word-wide memory. Word stores write directly;
// half/byte stores read the word, merge the lane and write it back.
//   clk, reset   : clock (rising edge), asynchronous active-low reset
//   start        : request pulse, sampled only in IDLE
//   SScontroler  : 00 word, 01 half, 10 byte, 11 no-op
//   addr, B_in   : store address and data
//   busy, done   : busy outside IDLE; one-cycle completion pulse
//   align_err    : misaligned half (only with STORE_LANE_EN)
//   mem          : memory port (store_aux_rmw_if.master)
// Build option: STORE_LANE_EN selects the lane from addr[1:0] and word-aligns
// mem_addr; without it the low lane is used and addr passes through.
module store_aux_rmw
  import store_pkg::*;
#(
  parameter int MEM_RD_LATENCY = 1,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        SScontroler,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       B_in,
  output logic              busy,
  output logic              done,
  output logic              align_err,
  store_aux_rmw_if.master   mem
);

  localparam int CNT_W = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LATENCY - 1);

  state_e            state;
  size_e             sz_q;
  logic [31:0]       b_q;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        lane;
  logic [31:0]       merged;
  logic [ADDR_W-1:0] addr_mem;
  logic              misaligned;
  size_e             sz_in;

  assign sz_in = size_e'(SScontroler);

`ifdef STORE_LANE_EN
  logic [1:0] lane_q;
  assign lane       = lane_q;
  assign addr_mem   = {addr[ADDR_W-1:2], 2'b00};
  assign misaligned = (sz_in == SZ_HALF) && addr[0];
`else
  assign lane       = 2'b00;
  assign addr_mem   = addr;
  assign misaligned = 1'b0;
`endif

  store_merge u_merge (
    .old_word (mem.mem_rdata),
    .b        (b_q),
    .size     (sz_q),
    .lane     (lane),
    .merged   (merged)
  );

  // mem_addr doubles as the latched address: it is loaded on start and held
  // until the FSM returns to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      align_err     <= 1'b0;
      mem.mem_wr    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      cnt           <= '0;
      b_q           <= '0;
      sz_q          <= SZ_WORD;
`ifdef STORE_LANE_EN
      lane_q        <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            b_q  <= B_in;
            sz_q <= sz_in;
            busy <= 1'b1;
            cnt  <= '0;
`ifdef STORE_LANE_EN
            lane_q <= addr[1:0];
`endif
            case (sz_in)
              SZ_WORD: begin
                state         <= WRITE;
                mem.mem_wr    <= 1'b1;
                mem.mem_wdata <= B_in;
                mem.mem_addr  <= addr_mem;
              end
              SZ_HALF, SZ_BYTE: begin
                if (misaligned) begin
                  // Rejected without touching memory; done still pulses.
                  state     <= DONE;
                  done      <= 1'b1;
                  align_err <= 1'b1;
                end else begin
                  state        <= READ;
                  mem.mem_addr <= addr_mem;
                end
              end
              default: begin
                state <= DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end
        READ: begin
          if (cnt == CNT_LAST) state <= MERGE;
          else                 cnt   <= cnt + 1'b1;
        end
        MERGE: begin
          mem.mem_wdata <= merged;
          mem.mem_wr    <= 1'b1;
          state         <= WRITE;
        end
        WRITE: begin
          mem.mem_wr <= 1'b0;
          done       <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          done         <= 1'b0;
          align_err    <= 1'b0;
          busy         <= 1'b0;
          mem.mem_addr <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_aux_rmw.sv
module tb_store_aux_rmw;
  import store_pkg::*;

  typedef struct {int inst; int cyc; logic [31:0] addr; logic [31:0] data;} wexp_t;
  typedef struct {int inst; int cyc; logic ae;} dexp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [1:0]  ss;
  logic [31:0] addr, b;
  logic        busy0, done0, ae0, busy1, done1, ae1;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  wexp_t wq[$];
  dexp_t dq[$];

  logic [31:0]       mem0[64];
  logic [31:0]       mem1[64];
  logic [31:0]       p0;
  logic [2:0][31:0]  p1;

  store_aux_rmw_if #(.ADDR_W(32)) m0();
  store_aux_rmw_if #(.ADDR_W(32)) m1();

  store_aux_rmw #(.MEM_RD_LATENCY(1), .ADDR_W(32)) u0 (
    .clk(clk), .reset(reset), .start(start0), .SScontroler(ss), .addr(addr),
    .B_in(b), .busy(busy0), .done(done0), .align_err(ae0), .mem(m0)
  );
  store_aux_rmw #(.MEM_RD_LATENCY(3), .ADDR_W(32)) u1 (
    .clk(clk), .reset(reset), .start(start1), .SScontroler(ss), .addr(addr),
    .B_in(b), .busy(busy1), .done(done1), .align_err(ae1), .mem(m1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fill(input int k);
    if (k == 16) return 32'h11223344;
    if (k == 17) return 32'hCAFEF00D;
    return 32'hBAD00000 | 32'(k);
  endfunction

  // Memory models: reloaded while reset is low; read data delayed by L cycles
  // so a DUT sampling mem_rdata early sees a stale word.
  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 64; k++) begin
        mem0[k] <= fill(k);
        mem1[k] <= fill(k);
      end
    end else begin
      if (m0.mem_wr) mem0[m0.mem_addr[7:2]] <= m0.mem_wdata;
      if (m1.mem_wr) mem1[m1.mem_addr[7:2]] <= m1.mem_wdata;
    end
    p0 <= mem0[m0.mem_addr[7:2]];
    p1 <= {p1[1:0], mem1[m1.mem_addr[7:2]]};
  end
  assign m0.mem_rdata = p0;
  assign m1.mem_rdata = p1[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic dn, input logic ae);
    wexp_t we;
    dexp_t de;
    if (wr) begin
      nvec++;
      if (wq.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_wr inst%0d cyc=%0d addr=%h data=%h", i, cyc, a, d);
      end else begin
        we = wq.pop_front();
        if (we.inst != i || we.cyc != cyc || we.addr !== a || we.data !== d) begin
          nerr++;
          $display("FAIL wr: got inst%0d cyc=%0d addr=%h data=%h want inst%0d cyc=%0d addr=%h data=%h",
                   i, cyc, a, d, we.inst, we.cyc, we.addr, we.data);
        end
      end
    end
    if (dn) begin
      nvec++;
      if (dq.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_done inst%0d cyc=%0d", i, cyc);
      end else begin
        de = dq.pop_front();
        if (de.inst != i || de.cyc != cyc || de.ae !== ae) begin
          nerr++;
          $display("FAIL done: got inst%0d cyc=%0d ae=%b want inst%0d cyc=%0d ae=%b",
                   i, cyc, ae, de.inst, de.cyc, de.ae);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon(0, m0.mem_wr, m0.mem_addr, m0.mem_wdata, done0, ae0);
      mon(1, m1.mem_wr, m1.mem_addr, m1.mem_wdata, done1, ae1);
    end
  end

  // Issue one store; wr_off < 0 means no write is expected.
  task automatic op(input int i, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                    input int wr_off, input logic [31:0] wa, input logic [31:0] wd,
                    input int dn_off, input logic ae);
    int k;
    logic bz;
    @(negedge clk);
    ss = s; addr = a; b = d;
    if (i == 0) start0 = 1'b1; else start1 = 1'b1;
    k = cyc;
    if (wr_off >= 0) wq.push_back('{i, k + wr_off, wa, wd});
    dq.push_back('{i, k + dn_off, ae});
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    bz = 1'b1;
    for (int n = 0; n < 20 && bz; n++) begin
      bz = (i == 0) ? busy0 : busy1;
      if (bz) @(negedge clk);
    end
    chk("op_timeout_busy", {31'd0, bz}, 32'd0);
    chk("idle_mem_addr", (i == 0) ? m0.mem_addr : m1.mem_addr, 32'd0);
  endtask

  initial begin
    int k;
    reset = 1'b0; start0 = 1'b0; start1 = 1'b0; ss = 2'b00; addr = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {30'd0, busy0, busy1}, 32'd0);
    chk("rst_done",   {30'd0, done0, done1}, 32'd0);
    chk("rst_ae",     {30'd0, ae0, ae1}, 32'd0);
    chk("rst_wr",     {30'd0, m0.mem_wr, m1.mem_wr}, 32'd0);
    chk("rst_addr0",  m0.mem_addr, 32'd0);
    chk("rst_wdata1", m1.mem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // sh, L=1: 0x11223344 with low half 0x5555
    op(0, 2'b01, 32'h40, 32'hAAAA5555, 3, 32'h40, 32'h11225555, 4, 1'b0);
    // sb, L=3
    op(1, 2'b10, 32'h40, 32'h000000CC, 5, 32'h40, 32'h112233CC, 6, 1'b0);
    // sw: direct write, no read cycles
    op(0, 2'b00, 32'h40, 32'hDEADBEEF, 1, 32'h40, 32'hDEADBEEF, 2, 1'b0);
    // no-op: done only
    op(0, 2'b11, 32'h44, 32'h12345678, -1, 32'h0, 32'h0, 1, 1'b0);

    // start pulses during READ, WRITE and DONE are ignored
    @(negedge clk);
    ss = 2'b01; addr = 32'h44; b = 32'h12345678; start1 = 1'b1;
    k = cyc;
    wq.push_back('{1, k + 5, 32'h44, 32'hCAFE5678});
    dq.push_back('{1, k + 6, 1'b0});
    for (int off = 1; off <= 7; off++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", off), {31'd0, busy1}, (off <= 6) ? 32'd1 : 32'd0);
      start1 = (off == 2 || off == 5 || off == 6);
      ss = 2'b00; addr = 32'h48; b = 32'hFFFFFFFF;
    end
    start1 = 1'b0;

`ifndef STORE_LANE_EN
    // Without lane selection: addr passes through, low lane always, no align_err
    op(0, 2'b01, 32'h41, 32'h99997777, 3, 32'h41, 32'hDEAD7777, 4, 1'b0);
    op(1, 2'b10, 32'h44, 32'hFFFFFF5A, 5, 32'h44, 32'hCAFE565A, 6, 1'b0);
`endif

    // Reset mid-operation: word store in WRITE (inst0), half store in READ (inst1)
    @(negedge clk);
    ss = 2'b00; addr = 32'h48; b = 32'h5A5A5A5A; start0 = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    start0 = 1'b0;
    #1;
    chk("rstmid_wr0",   {31'd0, m0.mem_wr}, 32'd0);
    chk("rstmid_busy0", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ss = 2'b01; addr = 32'h44; b = 32'h0000ABCD; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    chk("rd_busy1", {31'd0, busy1}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_busy1", {31'd0, busy1}, 32'd0);
    chk("rstmid_wr1",   {31'd0, m1.mem_wr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_partial_wr0", mem0[18], 32'hBAD00012);
    chk("no_partial_wr1", mem1[17], 32'hCAFEF00D);

`ifdef STORE_LANE_EN
    // Memory was reloaded by the reset above
    op(1, 2'b10, 32'h43, 32'h0000007F, 5, 32'h40, 32'h7F223344, 6, 1'b0);
    op(0, 2'b01, 32'h41, 32'h00001234, -1, 32'h0, 32'h0, 1, 1'b1);
    op(0, 2'b01, 32'h42, 32'h0000ABCD, 3, 32'h40, 32'hABCD3344, 4, 1'b0);
    op(0, 2'b10, 32'h41, 32'h00000055, 3, 32'h40, 32'hABCD5544, 4, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
